// File: rtl/cart_rom_fetch.sv
// ROM-side responder for the cart mapper: fetches 16-bit SDRAM words over a toggle
// handshake into a tagged buffer. Define CART_ROM_PREFETCH_EN to add a next-word prefetch buffer.
module cart_rom_fetch #(
  parameter int ADDR_W      = 25,
  parameter int MEM_AW      = 24,
  parameter int STALL_LIMIT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rom_address,
  input  logic              rom_rd,
  input  logic              flush,
  output logic [7:0]        rom_din,
  output logic              rom_ready,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic              stall_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL, S_PF_WAIT} state_t;

  localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

  state_t            state;
  logic              buf_valid;
  logic [MEM_AW-1:0] buf_tag;
  logic [15:0]       buf_word;
  logic [MEM_AW-1:0] req_tag;
  logic [15:0]       fill_word;
  logic              req_flushed;
  logic [7:0]        stall_cnt;

  logic [MEM_AW-1:0] addr_tag;
  logic              hs_idle;
  logic              dem_hit;

  assign addr_tag = rom_address[ADDR_W-1:1];
  assign hs_idle  = (mem_req == mem_ack);
  assign dem_hit  = buf_valid && (buf_tag == addr_tag);

`ifdef CART_ROM_PREFETCH_EN
  logic              pf_valid;
  logic [MEM_AW-1:0] pf_tag;
  logic [15:0]       pf_word;
  logic              pf_hit;

  assign pf_hit    = pf_valid && (pf_tag == addr_tag);
  assign rom_ready = dem_hit || pf_hit;
`else
  assign rom_ready = dem_hit;
`endif

  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of inferred latches.
    rom_din = 8'hFF;
    if (dem_hit) begin
      rom_din = rom_address[0] ? buf_word[15:8] : buf_word[7:0];
`ifdef CART_ROM_PREFETCH_EN
    end else if (pf_hit) begin
      rom_din = rom_address[0] ? pf_word[15:8] : pf_word[7:0];
`endif
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_word    <= '0;
      req_tag     <= '0;
      fill_word   <= '0;
      req_flushed <= 1'b0;
      stall_cnt   <= '0;
      stall_err   <= 1'b0;
`ifdef CART_ROM_PREFETCH_EN
      pf_valid    <= 1'b0;
      pf_tag      <= '0;
      pf_word     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef CART_ROM_PREFETCH_EN
          if (rom_rd && !dem_hit && pf_hit) begin
            // Promote the prefetched word and immediately chase the next one.
            buf_valid <= 1'b1;
            buf_tag   <= pf_tag;
            buf_word  <= pf_word;
            pf_valid  <= 1'b0;
            if (hs_idle) begin
              mem_addr    <= pf_tag + 1'b1;
              req_tag     <= pf_tag + 1'b1;
              mem_req     <= ~mem_req;
              req_flushed <= 1'b0;
              state       <= S_PF_WAIT;
            end
          end else
`endif
          if (rom_rd && !dem_hit && hs_idle) begin
            mem_addr    <= addr_tag;
            req_tag     <= addr_tag;
            mem_req     <= ~mem_req;
            req_flushed <= 1'b0;
            state       <= S_WAIT;
`ifdef CART_ROM_PREFETCH_EN
            pf_valid    <= 1'b0;
`endif
          end
        end

        S_WAIT, S_PF_WAIT: begin
          if (flush) req_flushed <= 1'b1;
          if (hs_idle) begin
`ifdef CART_ROM_PREFETCH_EN
            if (state == S_PF_WAIT) begin
              pf_valid  <= !req_flushed;
              pf_tag    <= req_tag;
              pf_word   <= mem_data;
              stall_cnt <= '0;
              state     <= S_IDLE;
            end else begin
              fill_word <= mem_data;
              state     <= S_FILL;
            end
`else
            fill_word <= mem_data;
            state     <= S_FILL;
`endif
          end else begin
            // Saturating wait counter; the request is never abandoned.
            if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 8'd1;
            if (stall_cnt == STALL_MAX - 8'd1) stall_err <= 1'b1;
          end
        end

        S_FILL: begin
          stall_cnt <= '0;
          state     <= S_IDLE;
          if (!req_flushed) begin
            buf_valid <= 1'b1;
            buf_tag   <= req_tag;
            buf_word  <= fill_word;
`ifdef CART_ROM_PREFETCH_EN
            mem_addr    <= req_tag + 1'b1;
            req_tag     <= req_tag + 1'b1;
            mem_req     <= ~mem_req;
            req_flushed <= 1'b0;
            pf_valid    <= 1'b0;
            state       <= S_PF_WAIT;
`endif
          end
        end
      endcase

      // NOTE: placed last so its non-blocking update wins over any fill in the same edge.
      if (flush) begin
        buf_valid <= 1'b0;
`ifdef CART_ROM_PREFETCH_EN
        pf_valid  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Self-checking bench for cart_rom_fetch (default build): directed handshake/flush/stall/reset
// sequences, a combinational vector table, and randomized accesses against a one-word cache model.
module tb_cart_rom_fetch;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] rom_address = '0;
  logic        rom_rd = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  rom_din;
  logic        rom_ready;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        stall_err;

  int total = 0;
  int bad = 0;
  int toggles = 0;

  cart_rom_fetch dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .rom_address (rom_address),
    .rom_rd      (rom_rd),
    .flush       (flush),
    .rom_din     (rom_din),
    .rom_ready   (rom_ready),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .stall_err   (stall_err)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM contents: a few fixed words, everything else a hash of the address.
  function automatic logic [15:0] word_of(input logic [23:0] a);
    if (a == 24'h000080) return 16'hBEEF;
    if (a == 24'h000100) return 16'h1234;
    return {a[7:0] ^ 8'hA5, a[15:8] ^ a[7:0] ^ 8'h3C};
  endfunction

  function automatic logic [7:0] byte_of(input logic [24:0] a);
    logic [15:0] w;
    w = word_of(a[24:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // SDRAM responder: latches each new request, acks after ack_delay cycles unless held.
  int          ack_delay = 2;
  bit          ack_hold = 1'b0;
  bit          sd_busy;
  int          sd_cnt;
  logic [23:0] sd_addr;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack  <= 1'b0;
      mem_data <= '0;
      sd_busy  <= 1'b0;
      sd_cnt   <= 0;
      sd_addr  <= '0;
    end else if (sd_busy) begin
      if (!ack_hold) begin
        if (sd_cnt == 0) begin
          mem_data <= word_of(sd_addr);
          mem_ack  <= ~mem_ack;
          sd_busy  <= 1'b0;
        end else begin
          sd_cnt <= sd_cnt - 1;
        end
      end
    end else if (mem_req != mem_ack) begin
      sd_busy <= 1'b1;
      sd_cnt  <= ack_delay;
      sd_addr <= mem_addr;
    end
  end

  always @(mem_req) if (reset_n) toggles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk_sys);
      ok = rom_ready;
    end
  endtask

  typedef struct {
    logic [24:0] addr;
    logic        exp_ready;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit          ok;
    int          t0;
    int          errs;
    bit          m_valid;
    logic [23:0] m_tag;
    logic [24:0] pool[8];

    vecs[0] = '{25'h0000200, 1'b1, 8'h34};
    vecs[1] = '{25'h0000201, 1'b1, 8'h12};
    vecs[2] = '{25'h0000202, 1'b0, 8'hFF};
    vecs[3] = '{25'h00001FF, 1'b0, 8'hFF};
    vecs[4] = '{25'h0000100, 1'b0, 8'hFF};
    vecs[5] = '{25'h0001200, 1'b0, 8'hFF};
    vecs[6] = '{25'h1000200, 1'b0, 8'hFF};

    pool[0] = 25'h0000100; pool[1] = 25'h0000101; pool[2] = 25'h0000200;
    pool[3] = 25'h0000201; pool[4] = 25'h0000202; pool[5] = 25'h1FFFFFF;
    pool[6] = 25'h1FFFFFE; pool[7] = 25'h0000000;

    // Reset state
    #12;
    check("reset mem_req", mem_req, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset rom_ready", rom_ready, 0);
    check("reset rom_din", rom_din, 8'hFF);
    check("reset stall_err", stall_err, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    // First miss and neighbour-byte hit
    ack_delay = 2;
    rom_address = 25'h0000100;
    rom_rd = 1'b1;
    @(negedge clk_sys);
    check("t1 mem_addr", mem_addr, 24'h000080);
    check("t1 ready during wait", rom_ready, 0);
    wait_ready(40, ok);
    check("t1 ready", ok, 1);
    check("t1 din", rom_din, 8'hEF);
    check("t1 toggles", toggles, 1);
    rom_address = 25'h0000101;
    #1;
    check("t1 din hi", rom_din, 8'hBE);
    check("t1 ready hi", rom_ready, 1);

    // Repeated hits: no traffic, ready held
    t0 = toggles;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      rom_address = (i % 2 == 0) ? 25'h0000100 : 25'h0000101;
      #1;
      if (!rom_ready || rom_din != ((i % 2 == 0) ? 8'hEF : 8'hBE)) errs++;
    end
    check("t2 hit loop errors", errs, 0);
    check("t2 toggles", toggles - t0, 0);

    // Flush while waiting: handshake completes, data discarded, request reissued
    t0 = toggles;
    ack_delay = 3;
    @(negedge clk_sys);
    rom_address = 25'h0000200;
    @(negedge clk_sys);
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (mem_ack == mem_req) ok = 1'b1;
      else @(negedge clk_sys);
    end
    check("t3 first ack", ok, 1);
    repeat (3) @(negedge clk_sys);
    check("t3 ready after discard", rom_ready, 0);
    check("t3 reissue toggles", toggles - t0, 2);
    check("t3 reissue addr", mem_addr, 24'h000100);
    wait_ready(40, ok);
    check("t3 ready", ok, 1);
    check("t3 din", rom_din, 8'h34);

    // Combinational hit/miss vectors against the buffered word 0x100 (no reads issued)
    t0 = toggles;
    rom_rd = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_sys);
      rom_address = vecs[i].addr;
      #1;
      check($sformatf("vec%0d ready", i), rom_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d din", i), rom_din, vecs[i].exp_din);
    end
    repeat (3) @(negedge clk_sys);
    check("vec toggles with rd low", toggles - t0, 0);

    // Withheld ack: stall_err on the 255th wait cycle, sticky, data still fills
    ack_hold = 1'b1;
    ack_delay = 0;
    rom_address = 25'h0000300;
    rom_rd = 1'b1;
    repeat (255) @(negedge clk_sys);
    check("t4 stall_err before limit", stall_err, 0);
    @(negedge clk_sys);
    check("t4 stall_err at limit", stall_err, 1);
    repeat (44) @(negedge clk_sys);
    ack_hold = 1'b0;
    wait_ready(20, ok);
    check("t4 ready after late ack", ok, 1);
    check("t4 din", rom_din, byte_of(25'h0000300));
    check("t4 stall_err sticky", stall_err, 1);

    // Asynchronous reset in the middle of a wait
    ack_hold = 1'b1;
    rom_address = 25'h0000400;
    repeat (4) @(negedge clk_sys);
    check("t5 addr held", mem_addr, 24'h000200);
    check("t5 mem_req before reset", mem_req, 1);
    rom_address = 25'h0000300;
    #1;
    check("t5 old word hit during wait", rom_ready, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5 mem_req", mem_req, 0);
    check("t5 ready", rom_ready, 0);
    check("t5 din", rom_din, 8'hFF);
    check("t5 stall_err", stall_err, 0);
    ack_hold = 1'b0;
    rom_rd = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    m_valid = 1'b0;
    m_tag = '0;

    // Randomized accesses against a one-word cache model
    for (int it = 0; it < 60; it++) begin
      logic [24:0] a;
      bit          rd;
      bit          do_flush;
      bit          hit;
      a = pool[$urandom_range(0, 7)];
      rd = ($urandom_range(0, 4) != 0);
      do_flush = ($urandom_range(0, 5) == 0);
      ack_delay = $urandom_range(0, 5);
      @(negedge clk_sys);
      rom_address = a;
      rom_rd = rd;
      t0 = toggles;
      #1;
      hit = m_valid && (m_tag == a[24:1]);
      check($sformatf("rnd%0d ready", it), rom_ready, hit);
      check($sformatf("rnd%0d din", it), rom_din, hit ? byte_of(a) : 8'hFF);
      if (hit && do_flush) begin
        @(negedge clk_sys);
        flush = 1'b1;
        rom_rd = 1'b0;
        @(negedge clk_sys);
        flush = 1'b0;
        check($sformatf("rnd%0d ready after flush", it), rom_ready, 0);
        m_valid = 1'b0;
      end else if (!rd && !hit) begin
        repeat (4) @(negedge clk_sys);
        check($sformatf("rnd%0d no req with rd low", it), toggles - t0, 0);
      end else if (rd && !hit) begin
        if (do_flush) begin
          @(negedge clk_sys);
          flush = 1'b1;
          @(negedge clk_sys);
          flush = 1'b0;
        end
        wait_ready(60, ok);
        check($sformatf("rnd%0d fill", it), ok, 1);
        check($sformatf("rnd%0d fill din", it), rom_din, byte_of(a));
        check($sformatf("rnd%0d req count", it), toggles - t0, do_flush ? 2 : 1);
        m_valid = 1'b1;
        m_tag = a[24:1];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cart_rom_fetch.md
Name: cart_rom_fetch

Overview:
- ROM-side responder for the cartridge mapper.
- Takes the 25-bit byte address and read strobe that the mapper produces and fetches 16-bit words from the SDRAM port using a toggle handshake.
- Holds the fetched word in a tagged buffer and returns the addressed byte to the mapper, together with a ready flag.
- Sits between the cart mapper and the SDRAM controller in the core top level.

Parameters:
- ADDR_W, 25, byte address width from the mapper.
- MEM_AW, 24, word address width to SDRAM (ADDR_W-1).
- STALL_LIMIT, 255, clk_sys cycles to wait for mem_ack before flagging a stall error; 8-bit counter.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rom_address  in  ADDR_W  byte address from the mapper
- rom_rd  in  1  mapper read strobe (level; fetch only while high)
- flush  in  1  one-cycle pulse; invalidate all buffers (cart reload)
- rom_din  out  8  byte returned to the mapper
- rom_ready  out  1  rom_din is valid for the current rom_address
- mem_addr  out  MEM_AW  SDRAM word address
- mem_req  out  1  request toggle
- mem_ack  in  1  acknowledge toggle from SDRAM
- mem_data  in  16  SDRAM read word, valid when mem_ack==mem_req
- stall_err  out  1  sticky; a request exceeded STALL_LIMIT

Behaviour:
- Reset (async, reset_n low):
  - mem_req=0, mem_addr=0, buffer valid=0, tag=0, stall_err=0, stall counter=0, state IDLE.
  - rom_ready=0 and rom_din=8'hFF.
- Word tag = rom_address[ADDR_W-1:1].
- Hit = valid && tag==rom_address[ADDR_W-1:1].
- rom_ready and rom_din are combinational from the hit:
  - Hit: rom_din = rom_address[0] ? word[15:8] : word[7:0] (little-endian); rom_ready=1.
  - Miss: rom_ready=0 and rom_din=8'hFF.
- Toggle handshake:
  - The block may issue a request only when mem_req==mem_ack.
  - Issue = load mem_addr, then invert mem_req in the same edge.
  - A request completes on the first edge where mem_ack==mem_req.
  - mem_addr stays stable while the request is outstanding.
- FSM:
  - IDLE: if rom_rd && !hit && mem_req==mem_ack, issue for the word tag, latch the requested tag, go to WAIT. Otherwise stay in IDLE.
  - WAIT: the stall counter increments each cycle. When it reaches STALL_LIMIT, set stall_err and keep waiting (no abort). On completion, go to FILL.
  - FILL: one cycle. If no flush occurred during the request, write the buffer with mem_data, set the tag to the requested tag and valid=1. Clear the stall counter. Go to IDLE.
- Miss latency: rom_ready rises 2 cycles after the completing edge, i.e. after the FILL cycle. A back-to-back miss issues on the cycle after FILL.
- Address changes while in WAIT are ignored until FILL. A miss on the new address is then re-evaluated from IDLE.
- flush:
  - Clears valid immediately.
  - If a request is outstanding, it still completes the handshake (never abandoned), but its data is discarded and valid stays 0.
  - flush together with the completing edge: the data is discarded.
- rom_rd low: no new requests are issued. A request already in flight runs to completion.
- Tag compare and address arithmetic are unsigned. Word address wrap at 2^MEM_AW is natural overflow.
- stall_err clears only on reset.

Optional Feature:
- Macro: CART_ROM_PREFETCH_EN.
- Enabled: a second tagged word buffer (prefetch) is added.
  - After every demand FILL, a request for tag+1 is issued automatically (PF_WAIT state) and written to the prefetch buffer.
  - A demand access whose tag matches a valid prefetch buffer is a hit, with zero latency.
  - On the first clk_sys edge of that hit, the prefetch word moves to the demand buffer and the next prefetch (tag+1) is issued.
  - A demand miss during PF_WAIT waits for that completion. The prefetched word is kept if its tag matches, otherwise it is dropped, then the demand request is issued.
  - flush invalidates both buffers.
- Disabled: single buffer; no requests other than demand misses.

Test Plan:
- Reset release, rom_rd=1, rom_address=0x00100, mem_ack echoes after 3 cycles with mem_data=16'hBEEF -> mem_addr=0x00080, one mem_req toggle, rom_ready=1 with rom_din=8'hEF; then address 0x00101 -> rom_din=8'hBE with no new toggle.
- Hit sequence 0x00100/0x00101 repeated 100 cycles -> zero further mem_req toggles, rom_ready held 1.
- flush pulse while WAIT for 0x00200, ack returns 16'h1234 -> handshake completes, rom_ready stays 0, new request reissued for word 0x00100 on next IDLE.
- mem_ack withheld 300 cycles -> stall_err=1 at cycle 255 of WAIT, stays 1 after late ack; data then fills normally.
- reset_n asserted mid-WAIT -> mem_req=0, rom_ready=0, rom_din=8'hFF asynchronously; SDRAM model reset with it.
- With CART_ROM_PREFETCH_EN, sequential reads 0x00100..0x00107 -> after first fill, rom_ready never drops for 0x00102.. once each prefetch lands; mem_addr sequence 0x80,0x81,0x82,0x83,0x84.
